// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multicycle MIPS-subset control FSM. Sequences fetch, decode
//               and per-instruction execute states and drives every write
//               enable, mux select and operation code of the datapath.
//               Outputs are a function of the state register (plus a few
//               fields latched at DECODE); the branch-taken enable is the one
//               output that also looks at the ALU equal flag.
// Ports       : clk, reset (async, active low)
//               OPCODE/FUNCT  instruction fields from the IR
//               O/ET          ALU overflow / equal flags
//               *_w           datapath write enables
//               ALU_op, Shift_op, M_*  operation codes and mux selects
//               STATE         current state code
// Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter logic [1:0] EXC_OPC_SEL = 2'b00,
    parameter logic [1:0] EXC_OVF_SEL = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       O,
    input  logic       ET,
    output logic       PC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       REG_w,
    output logic       AB_w,
    output logic       EPC_w,
    output logic       HI_w,
    output logic       LO_w,
    output logic       MDR_w,
    output logic       ALUOut_w,
    output logic [2:0] ALU_op,
    output logic [2:0] Shift_op,
    output logic [1:0] M_SrcA,
    output logic [1:0] M_SrcB,
    output logic [1:0] M_RMEM,
    output logic [1:0] M_EXCEPTION,
    output logic [1:0] M_WRITE_REG,
    output logic [2:0] M_WRITE_DATA,
    output logic [1:0] M_PC,
    output logic       M_Shift_In,
    output logic       M_Shift_N,
    output logic [4:0] STATE
);

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,  S_FETCH    = 5'd1,  S_FETCH2   = 5'd2,
        S_DECODE   = 5'd3,  S_ALU_EX   = 5'd4,  S_ALU_WB   = 5'd5,
        S_SLT      = 5'd6,  S_SH_LD    = 5'd7,  S_SH_OP    = 5'd8,
        S_SH_WB    = 5'd9,  S_MFHI     = 5'd10, S_MFLO     = 5'd11,
        S_JR       = 5'd12, S_ADDI_EX  = 5'd13, S_ADDI_WB  = 5'd14,
        S_MEM_ADDR = 5'd15, S_LW_RD    = 5'd16, S_LW_WAIT  = 5'd17,
        S_LW_WB    = 5'd18, S_SW_WR    = 5'd19, S_BRANCH   = 5'd20,
        S_J        = 5'd21, S_JAL      = 5'd22, S_LUI      = 5'd23,
        S_EXC_EPC  = 5'd24, S_EXC_RD   = 5'd25, S_EXC_WAIT = 5'd26,
        S_EXC_PC   = 5'd27
    } state_t;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_CMP   = 3'b111;

    state_t     state, state_next;
    logic [1:0] exc_sel, exc_sel_next;
    logic [2:0] alu_fn, alu_fn_dec;     // R-type ALU op, held from DECODE
    logic [2:0] shift_fn, shift_fn_dec; // shift kind, held from DECODE
    logic       is_bne;

    // Fields that select behaviour inside later states are captured at
    // DECODE so those states depend only on registered information.
    always_comb begin
        alu_fn_dec   = ALU_ADD;
        shift_fn_dec = 3'b010;
        case (FUNCT)
            6'h22:   alu_fn_dec = ALU_SUB;
            6'h24:   alu_fn_dec = ALU_AND;
            default: alu_fn_dec = ALU_ADD;
        endcase
        case (FUNCT)
            6'h02:   shift_fn_dec = 3'b011;
            6'h03:   shift_fn_dec = 3'b100;
            default: shift_fn_dec = 3'b010;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RESET;
            exc_sel  <= EXC_OPC_SEL;
            alu_fn   <= ALU_ADD;
            shift_fn <= 3'b010;
            is_bne   <= 1'b0;
        end else begin
            state   <= state_next;
            exc_sel <= exc_sel_next;
            if (state == S_DECODE) begin
                alu_fn   <= alu_fn_dec;
                shift_fn <= shift_fn_dec;
                is_bne   <= (OPCODE == 6'h05);
            end
        end
    end

    // Next-state logic. Every state except RESET lasts one cycle, so the
    // default successor is FETCH.
    always_comb begin
        state_next   = S_FETCH;
        exc_sel_next = exc_sel;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    6'h00: begin
                        case (FUNCT)
                            6'h20, 6'h22, 6'h24: state_next = S_ALU_EX;
                            6'h2A:               state_next = S_SLT;
                            6'h00, 6'h02, 6'h03: state_next = S_SH_LD;
                            6'h10:               state_next = S_MFHI;
                            6'h12:               state_next = S_MFLO;
                            6'h08:               state_next = S_JR;
                            default: begin
                                state_next   = S_EXC_EPC;
                                exc_sel_next = EXC_OPC_SEL;
                            end
                        endcase
                    end
                    6'h08:        state_next = S_ADDI_EX;
                    6'h23, 6'h2B: state_next = S_MEM_ADDR;
                    6'h04, 6'h05: state_next = S_BRANCH;
                    6'h02:        state_next = S_J;
                    6'h03:        state_next = S_JAL;
                    6'h0F:        state_next = S_LUI;
                    default: begin
                        state_next   = S_EXC_EPC;
                        exc_sel_next = EXC_OPC_SEL;
                    end
                endcase
            end
            S_ALU_EX: begin
                // 'and' cannot overflow; only add/sub trap.
                if (O && (alu_fn != ALU_AND)) begin
                    state_next   = S_EXC_EPC;
                    exc_sel_next = EXC_OVF_SEL;
                end else begin
                    state_next = S_ALU_WB;
                end
            end
            S_ADDI_EX: begin
                if (O) begin
                    state_next   = S_EXC_EPC;
                    exc_sel_next = EXC_OVF_SEL;
                end else begin
                    state_next = S_ADDI_WB;
                end
            end
            S_SH_LD:    state_next = S_SH_OP;
            S_SH_OP:    state_next = S_SH_WB;
            S_MEM_ADDR: state_next = (OPCODE == 6'h2B) ? S_SW_WR : S_LW_RD;
            S_LW_RD:    state_next = S_LW_WAIT;
            S_LW_WAIT:  state_next = S_LW_WB;
            S_EXC_EPC:  state_next = S_EXC_RD;
            S_EXC_RD:   state_next = S_EXC_WAIT;
            S_EXC_WAIT: state_next = S_EXC_PC;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode.
    always_comb begin
        PC_w = 1'b0; MEM_w = 1'b0; IR_w = 1'b0; REG_w = 1'b0; AB_w = 1'b0;
        EPC_w = 1'b0; HI_w = 1'b0; LO_w = 1'b0; MDR_w = 1'b0; ALUOut_w = 1'b0;
        ALU_op = ALU_PASSA; Shift_op = 3'b000;
        M_SrcA = 2'b00; M_SrcB = 2'b00; M_RMEM = 2'b00; M_EXCEPTION = 2'b00;
        M_WRITE_REG = 2'b00; M_WRITE_DATA = 3'b000; M_PC = 2'b00;
        M_Shift_In = 1'b0; M_Shift_N = 1'b0;
        case (state)
            S_FETCH: begin
                M_SrcB = 2'b01; ALU_op = ALU_ADD;
            end
            S_FETCH2: begin
                // ALU keeps producing PC+4 while the IR and PC are written.
                M_SrcB = 2'b01; ALU_op = ALU_ADD;
                IR_w = 1'b1; PC_w = 1'b1;
            end
            S_DECODE: begin
                AB_w = 1'b1; ALUOut_w = 1'b1;
                M_SrcB = 2'b11; ALU_op = ALU_ADD;
            end
            S_ALU_EX: begin
                M_SrcA = 2'b01; ALU_op = alu_fn; ALUOut_w = 1'b1;
            end
            S_ALU_WB: begin
                REG_w = 1'b1; M_WRITE_REG = 2'b01; M_WRITE_DATA = 3'b001;
            end
            S_SLT: begin
                M_SrcA = 2'b01; ALU_op = ALU_CMP;
                REG_w = 1'b1; M_WRITE_REG = 2'b01; M_WRITE_DATA = 3'b101;
            end
            S_SH_LD: begin
                Shift_op = 3'b001; M_Shift_In = 1'b1;
            end
            S_SH_OP: Shift_op = shift_fn;
            S_SH_WB: begin
                REG_w = 1'b1; M_WRITE_REG = 2'b01; M_WRITE_DATA = 3'b100;
            end
            S_MFHI: begin
                REG_w = 1'b1; M_WRITE_REG = 2'b01; M_WRITE_DATA = 3'b010;
            end
            S_MFLO: begin
                REG_w = 1'b1; M_WRITE_REG = 2'b01; M_WRITE_DATA = 3'b011;
            end
            S_JR: begin
                M_SrcA = 2'b01; ALU_op = ALU_PASSA; PC_w = 1'b1;
            end
            S_ADDI_EX, S_MEM_ADDR: begin
                M_SrcA = 2'b01; M_SrcB = 2'b10; ALU_op = ALU_ADD; ALUOut_w = 1'b1;
            end
            S_ADDI_WB: begin
                REG_w = 1'b1; M_WRITE_DATA = 3'b001;
            end
            S_LW_RD: M_RMEM = 2'b01;
            S_LW_WAIT: begin
                M_RMEM = 2'b01; MDR_w = 1'b1;
            end
            S_LW_WB: REG_w = 1'b1;
            S_SW_WR: begin
                M_RMEM = 2'b01; MEM_w = 1'b1;
            end
            S_BRANCH: begin
                // The compare resolves in this same cycle, so the taken
                // enable is qualified by ET directly (inverted for bne).
                M_SrcA = 2'b01; ALU_op = ALU_CMP; M_PC = 2'b01;
                PC_w = ET ^ is_bne;
            end
            S_J: begin
                M_PC = 2'b10; PC_w = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 here, which is the link value.
                REG_w = 1'b1; M_WRITE_REG = 2'b10; M_WRITE_DATA = 3'b110;
                M_PC = 2'b10; PC_w = 1'b1;
            end
            S_LUI: begin
                REG_w = 1'b1; M_WRITE_DATA = 3'b111;
            end
            S_EXC_EPC: begin
                M_SrcB = 2'b01; ALU_op = ALU_SUB; EPC_w = 1'b1;
            end
            S_EXC_RD: begin
                M_RMEM = 2'b10; M_EXCEPTION = exc_sel;
            end
            S_EXC_WAIT: begin
                M_RMEM = 2'b10; M_EXCEPTION = exc_sel; MDR_w = 1'b1;
            end
            S_EXC_PC: begin
                M_PC = 2'b11; PC_w = 1'b1;
            end
            default: ;
        endcase
    end

    assign STATE = state;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed bench for control_unit. Walks instruction sequences
//               state by state and compares state codes and control outputs
//               against hand-derived values.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    localparam logic [4:0] S_RESET = 5'd0,  S_FETCH = 5'd1, S_FETCH2 = 5'd2,
        S_DECODE = 5'd3, S_ALU_EX = 5'd4, S_ALU_WB = 5'd5, S_SH_LD = 5'd7,
        S_SH_OP = 5'd8, S_SH_WB = 5'd9, S_MEM_ADDR = 5'd15, S_LW_RD = 5'd16,
        S_LW_WAIT = 5'd17, S_LW_WB = 5'd18, S_SW_WR = 5'd19, S_BRANCH = 5'd20,
        S_JAL = 5'd22, S_EXC_EPC = 5'd24, S_EXC_RD = 5'd25,
        S_EXC_WAIT = 5'd26, S_EXC_PC = 5'd27;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OPCODE = 6'h00;
    logic [5:0] FUNCT = 6'h00;
    logic       O = 1'b0;
    logic       ET = 1'b0;
    logic PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, HI_w, LO_w, MDR_w, ALUOut_w;
    logic [2:0] ALU_op, Shift_op, M_WRITE_DATA;
    logic [1:0] M_SrcA, M_SrcB, M_RMEM, M_EXCEPTION, M_WRITE_REG, M_PC;
    logic       M_Shift_In, M_Shift_N;
    logic [4:0] STATE;

    int tests_run = 0;
    int tests_failed = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .O(O), .ET(ET),
        .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .REG_w(REG_w), .AB_w(AB_w),
        .EPC_w(EPC_w), .HI_w(HI_w), .LO_w(LO_w), .MDR_w(MDR_w),
        .ALUOut_w(ALUOut_w), .ALU_op(ALU_op), .Shift_op(Shift_op),
        .M_SrcA(M_SrcA), .M_SrcB(M_SrcB), .M_RMEM(M_RMEM),
        .M_EXCEPTION(M_EXCEPTION), .M_WRITE_REG(M_WRITE_REG),
        .M_WRITE_DATA(M_WRITE_DATA), .M_PC(M_PC), .M_Shift_In(M_Shift_In),
        .M_Shift_N(M_Shift_N), .STATE(STATE)
    );

    always #5 clk = ~clk;

    logic [37:0] all_outs;
    assign all_outs = {PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, HI_w, LO_w, MDR_w,
                       ALUOut_w, ALU_op, Shift_op, M_SrcA, M_SrcB, M_RMEM,
                       M_EXCEPTION, M_WRITE_REG, M_WRITE_DATA, M_PC,
                       M_Shift_In, M_Shift_N, STATE};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bench sits in FETCH on entry; leaves it in the first dispatch state.
    task automatic start_instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
        OPCODE = op;
        FUNCT  = fn;
        check({tag, "_fetch"}, STATE, S_FETCH);
        check({tag, "_fetch_alu"}, {M_RMEM, M_SrcA, M_SrcB, ALU_op}, {2'b00, 2'b00, 2'b01, 3'b001});
        step();
        check({tag, "_fetch2"}, {STATE, IR_w, PC_w, M_PC}, {S_FETCH2, 1'b1, 1'b1, 2'b00});
        step();
        check({tag, "_decode"}, {STATE, AB_w, ALUOut_w}, {S_DECODE, 1'b1, 1'b1});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held low for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs", all_outs, 38'd0);
        end
        reset = 1'b1;
        step();

        // add, no overflow: 5 cycles FETCH to FETCH.
        start_instr("add", 6'h00, 6'h20);
        check("add_ex", {STATE, ALUOut_w, ALU_op, M_SrcA, M_SrcB}, {S_ALU_EX, 1'b1, 3'b001, 2'b01, 2'b00});
        step();
        check("add_wb", {STATE, REG_w, M_WRITE_REG, M_WRITE_DATA}, {S_ALU_WB, 1'b1, 2'b01, 3'b001});
        step();

        // add with overflow: trap, no register write.
        start_instr("ovf", 6'h00, 6'h20);
        O = 1'b1;
        check("ovf_ex", STATE, S_ALU_EX);
        step();
        O = 1'b0;
        check("ovf_epc", {STATE, EPC_w, REG_w, ALU_op}, {S_EXC_EPC, 1'b1, 1'b0, 3'b010});
        step();
        check("ovf_rd", {STATE, M_RMEM, M_EXCEPTION, REG_w}, {S_EXC_RD, 2'b10, 2'b01, 1'b0});
        step();
        check("ovf_wait", {STATE, MDR_w, M_EXCEPTION, REG_w}, {S_EXC_WAIT, 1'b1, 2'b01, 1'b0});
        step();
        check("ovf_pc", {STATE, PC_w, M_PC, REG_w}, {S_EXC_PC, 1'b1, 2'b11, 1'b0});
        step();

        // Branches: {opcode, ET, expected PC_w}.
        begin
            logic [7:0] br [4];
            br[0] = {6'h04, 1'b1, 1'b1};
            br[1] = {6'h04, 1'b0, 1'b0};
            br[2] = {6'h05, 1'b0, 1'b1};
            br[3] = {6'h05, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                start_instr("br", br[i][7:2], 6'h00);
                ET = br[i][1];
                #1;
                check("br_state", {STATE, M_PC}, {S_BRANCH, 2'b01});
                check("br_pcw", PC_w, br[i][0]);
                step();
                ET = 1'b0;
            end
        end

        // sll then srl.
        start_instr("sll", 6'h00, 6'h00);
        check("sll_ld", {STATE, Shift_op, M_Shift_In, M_Shift_N}, {S_SH_LD, 3'b001, 1'b1, 1'b0});
        step();
        check("sll_op", {STATE, Shift_op}, {S_SH_OP, 3'b010});
        step();
        check("sll_wb", {STATE, REG_w, M_WRITE_REG, M_WRITE_DATA}, {S_SH_WB, 1'b1, 2'b01, 3'b100});
        step();
        start_instr("srl", 6'h00, 6'h02);
        step();
        check("srl_op", {STATE, Shift_op}, {S_SH_OP, 3'b011});
        step();
        step();

        // lw: MDR_w exactly two cycles after MEM_ADDR, 7 cycles total.
        start_instr("lw", 6'h23, 6'h00);
        check("lw_addr", {STATE, ALUOut_w, M_SrcB, MDR_w}, {S_MEM_ADDR, 1'b1, 2'b10, 1'b0});
        step();
        check("lw_rd", {STATE, M_RMEM, MDR_w}, {S_LW_RD, 2'b01, 1'b0});
        step();
        check("lw_wait", {STATE, MDR_w}, {S_LW_WAIT, 1'b1});
        step();
        check("lw_wb", {STATE, REG_w, MDR_w, M_WRITE_REG, M_WRITE_DATA}, {S_LW_WB, 1'b1, 1'b0, 2'b00, 3'b000});
        step();

        // sw
        start_instr("sw", 6'h2B, 6'h00);
        step();
        check("sw_wr", {STATE, MEM_w, REG_w, M_RMEM}, {S_SW_WR, 1'b1, 1'b0, 2'b01});
        step();

        // jal
        start_instr("jal", 6'h03, 6'h00);
        check("jal", {STATE, REG_w, M_WRITE_REG, M_WRITE_DATA, PC_w, M_PC},
              {S_JAL, 1'b1, 2'b10, 3'b110, 1'b1, 2'b10});
        step();

        // Invalid opcode, then invalid R-type funct: opcode vector.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) start_instr("badop", 6'h3F, 6'h00);
            else        start_instr("badfn", 6'h00, 6'h3F);
            check("inv_epc", {STATE, EPC_w}, {S_EXC_EPC, 1'b1});
            step();
            check("inv_rd", {STATE, M_EXCEPTION, M_RMEM}, {S_EXC_RD, 2'b00, 2'b10});
            step();
            step();
            check("inv_pc", {STATE, PC_w, M_PC}, {S_EXC_PC, 1'b1, 2'b11});
            step();
        end

        // Reset during LW_WAIT aborts the load.
        start_instr("lwabort", 6'h23, 6'h00);
        step();
        step();
        check("abort_wait", STATE, S_LW_WAIT);
        reset = 1'b0;
        #1;
        check("abort_reset", {STATE, REG_w}, {S_RESET, 1'b0});
        OPCODE = 6'h02;
        step();
        check("abort_hold", all_outs, 38'd0);
        reset = 1'b1;
        step();
        check("abort_fetch", {STATE, REG_w}, {S_FETCH, 1'b0});
        step();
        check("abort_f2", REG_w, 1'b0);
        step();
        check("abort_dec", REG_w, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
